esc_drv: RTL and testbench
==========================

# esc_drv

Four-channel ESC driver sitting directly downstream of the flight controller: takes the 11-bit `frnt_spd`, `bck_spd`, `lft_spd` and `rght_spd` motor speeds and produces one OneShot-style PWM output per motor. Each channel converts its speed to a pulse width with a 2-stage pipeline. Pulse widths are double-buffered and only take effect at frame boundaries, so a pulse is never truncated or stretched mid-frame. A shared free-running frame counter sets the PWM period.

## Interface
Parameters:
- `PERIOD_W`, 20: frame counter width; frame period = 2^PERIOD_W clocks. Must satisfy 2^PERIOD_W > MIN_PULSE + SCALE*2047 + 1.
- `MIN_PULSE`, 6250: pulse width in clocks for speed 0 (125 µs at 50 MHz).
- `SCALE`, 3: clocks added per speed LSB.

Ports:
- `clk`  in  1  system clock; the only clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `arm`  in  1  1 = speeds drive pulses; 0 = every channel is forced to MIN_PULSE.
- `frnt_spd`  in  11  front motor speed, unsigned.
- `bck_spd`  in  11  back motor speed, unsigned.
- `lft_spd`  in  11  left motor speed, unsigned.
- `rght_spd`  in  11  right motor speed, unsigned.
- `frnt`  out  1  front ESC PWM.
- `bck`  out  1  back ESC PWM.
- `lft`  out  1  left ESC PWM.
- `rght`  out  1  right ESC PWM.
- `frame_strt`  out  1  one-cycle pulse marking each frame load.

## Operation
- Frame counter `cnt` (PERIOD_W bits):
  - increments every clock and wraps from 2^PERIOD_W-1 to 0;
  - has no other control.
- Per-channel pipeline:
  - Stage 1 registers `spd` and `arm` every clock.
  - Stage 2 computes `pulse = MIN_PULSE + SCALE*spd_q` when `arm_q` = 1, else MIN_PULSE, and registers it. Width is PULSE_W = 14 bits; maximum 6250 + 6141 = 12391, so there is no overflow.
- Active register:
  - On the clock edge where `cnt` == 0, `active_pulse` is loaded from the stage-2 register.
  - At all other edges it holds.
- PWM output (registered):
  - Set on the edge where `cnt` == 0.
  - Cleared on the edge where `cnt` == `active_pulse`, compared against the value just loaded.
  - Result: the output is high for exactly `active_pulse` clocks per frame, then low for the rest of the frame.
- `frame_strt`: registered; high for the single clock following the `cnt` == 0 edge, i.e. aligned with the first high cycle of each PWM output.
- All four channels share `cnt`, so rising edges of all PWM outputs are simultaneous.

## Timing
- Reset values: `cnt` = 0; all PWM outputs 0; `frame_strt` 0; stage-1 regs 0; stage-2 and `active_pulse` = MIN_PULSE.
- First frame after reset release:
  - Load edge occurs on the first clock, where `cnt` == 0.
  - First pulse width is MIN_PULSE, since the pipeline still holds reset values.
- Speed-to-pulse latency:
  - A speed/`arm` value present at clock edge E is in stage 2 after edge E+1.
  - It is used by the frame whose load edge is at or after E+2.
  - If it changes only 1 clock before the load edge, it lands in the following frame.
- Mid-frame speed changes never alter the current frame's pulse.
- `arm` deasserted mid-frame: current pulse completes unchanged; following frames are MIN_PULSE, subject to the same 2-clock latency.
- Reset asserted mid-operation: all outputs go low asynchronously and immediately; state returns to reset values.
- Input range: speed 0x7FF is legal and gives 12391. No saturation is needed because the spd input is only 11 bits.

## Structure
- Shared package `quad_pkg`: `SPD_W` = 11, `PULSE_W` = 14, `MIN_PULSE`, `SCALE`, and typedef `spd_t` (logic [10:0]).
- The frame counter and `frame_strt` live in the `esc_drv` top.
- Sub-module `esc_pwm_chan`, instantiated 4×:
  - inputs: `clk`, `rst_n`, `arm`, `spd`, `cnt`;
  - output: `pwm`;
  - contains the 2-stage pipeline, `active_pulse` register, and set/clear flop.

## Test plan
Bench uses PERIOD_W = 14 (frame = 16384 clocks) and measures high time per frame on each output.
- Reset, `arm` = 0, all speeds 0x400 → every channel high 6250 clocks per frame; `frame_strt` pulses every 16384 clocks, coincident with the PWM rising edges.
- `arm` = 1, frnt = 0x000, bck = 0x7FF, lft = 0x100, rght = 0x555 → high times 6250, 12391, 7018, 10345 from the second full frame on.
- frnt changed 0x000 → 0x7FF at `cnt` = 100 → current frame 6250, next frame 12391; no glitch on `frnt`.
- Speed change landing 2 clocks before the load edge → applied that frame; landing 1 clock before → applied the next frame.
- `arm` 1 → 0 mid-pulse with bck = 0x7FF → current bck pulse 12391, subsequent 6250.
- `rst_n` low during a pulse → all outputs 0 within the same cycle; after release, first frame is 6250 on all channels.

Source files
------------

// File: rtl/quad_pkg.sv
// ---------------------------------------------------------------------------
// quad_pkg : shared widths, pulse constants and speed-to-pulse conversion
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package quad_pkg;

    localparam int SPD_W     = 11;
    localparam int PULSE_W   = 14;
    localparam int MIN_PULSE = 6250;
    localparam int SCALE     = 3;

    typedef logic [SPD_W-1:0]   spd_t;
    typedef logic [PULSE_W-1:0] pulse_t;

    // Largest result is MIN_PULSE + SCALE*2047, which fits PULSE_W with the default constants.
    function automatic pulse_t spd_to_pulse(input spd_t spd, input logic arm,
                                            input int min_p, input int scale);
        int width;
        width = arm ? (min_p + scale * int'(spd)) : min_p;
        return pulse_t'(width);
    endfunction

endpackage

`default_nettype wire

// File: rtl/esc_pwm_chan.sv
// ---------------------------------------------------------------------------
// esc_pwm_chan : one ESC channel - 2-stage speed pipeline, frame-latched width, PWM flop
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module esc_pwm_chan
    import quad_pkg::*;
#(
    parameter int PERIOD_W  = 20,
    parameter int MIN_PULSE = quad_pkg::MIN_PULSE,
    parameter int SCALE     = quad_pkg::SCALE
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                arm,
    input  spd_t                spd,
    input  logic [PERIOD_W-1:0] cnt,
    output logic                pwm
);

    spd_t   spd_q;
    logic   arm_q;
    pulse_t pulse_q;
    pulse_t active_pulse;

    logic [PERIOD_W-1:0] active_ext;
    logic                frame_load;

    assign active_ext = PERIOD_W'(active_pulse);
    assign frame_load = (cnt == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            spd_q        <= '0;
            arm_q        <= 1'b0;
            pulse_q      <= pulse_t'(MIN_PULSE);
            active_pulse <= pulse_t'(MIN_PULSE);
            pwm          <= 1'b0;
        end else begin
            spd_q   <= spd;
            arm_q   <= arm;
            pulse_q <= spd_to_pulse(spd_q, arm_q, MIN_PULSE, SCALE);
            // The width only changes at the frame edge, so a running pulse is never cut or stretched.
            if (frame_load) begin
                active_pulse <= pulse_q;
                pwm          <= 1'b1;
            end else if (cnt == active_ext) begin
                pwm <= 1'b0;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/esc_drv.sv
// ---------------------------------------------------------------------------
// esc_drv : four-channel OneShot ESC driver sharing one free-running frame counter
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module esc_drv
    import quad_pkg::*;
#(
    parameter int PERIOD_W  = 20,
    parameter int MIN_PULSE = quad_pkg::MIN_PULSE,
    parameter int SCALE     = quad_pkg::SCALE
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             arm,
    input  logic [SPD_W-1:0] frnt_spd,
    input  logic [SPD_W-1:0] bck_spd,
    input  logic [SPD_W-1:0] lft_spd,
    input  logic [SPD_W-1:0] rght_spd,
    output logic             frnt,
    output logic             bck,
    output logic             lft,
    output logic             rght,
    output logic             frame_strt
);

    logic [PERIOD_W-1:0] cnt;
    spd_t                spd_v [4];
    logic [3:0]          pwm_v;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt        <= '0;
            frame_strt <= 1'b0;
        end else begin
            cnt        <= cnt + PERIOD_W'(1);
            frame_strt <= (cnt == '0);
        end
    end

    assign spd_v[0] = frnt_spd;
    assign spd_v[1] = bck_spd;
    assign spd_v[2] = lft_spd;
    assign spd_v[3] = rght_spd;

    generate
        for (genvar g = 0; g < 4; g++) begin : g_chan
            esc_pwm_chan #(
                .PERIOD_W  (PERIOD_W),
                .MIN_PULSE (MIN_PULSE),
                .SCALE     (SCALE)
            ) u_chan (
                .clk   (clk),
                .rst_n (rst_n),
                .arm   (arm),
                .spd   (spd_v[g]),
                .cnt   (cnt),
                .pwm   (pwm_v[g])
            );
        end
    endgenerate

    assign frnt = pwm_v[0];
    assign bck  = pwm_v[1];
    assign lft  = pwm_v[2];
    assign rght = pwm_v[3];

endmodule

`default_nettype wire

// File: tb/tb_esc_drv.sv
// ---------------------------------------------------------------------------
// tb_esc_drv : directed frame-by-frame pulse-width checks for esc_drv
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_esc_drv;

    localparam int FRAME = 16384;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        arm = 1'b0;
    logic [10:0] frnt_spd = 11'h400;
    logic [10:0] bck_spd  = 11'h400;
    logic [10:0] lft_spd  = 11'h400;
    logic [10:0] rght_spd = 11'h400;
    logic        frnt, bck, lft, rght, frame_strt;

    esc_drv #(.PERIOD_W(14)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .arm        (arm),
        .frnt_spd   (frnt_spd),
        .bck_spd    (bck_spd),
        .lft_spd    (lft_spd),
        .rght_spd   (rght_spd),
        .frnt       (frnt),
        .bck        (bck),
        .lft        (lft),
        .rght       (rght),
        .frame_strt (frame_strt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          idx;
        int          ch;
        logic [10:0] val;
    } chg_t;

    chg_t  chg_q[$];
    int    n_cmp = 0;
    int    n_bad = 0;
    int    hi[4];
    int    rises;
    int    fs_cnt;
    string nm[4] = '{"frnt", "bck", "lft", "rght"};

    task automatic apply(input int ch, input logic [10:0] v);
        case (ch)
            0:       frnt_spd = v;
            1:       bck_spd  = v;
            2:       lft_spd  = v;
            3:       rght_spd = v;
            default: arm      = v[0];
        endcase
    endtask

    // Starts on the negedge where frame_strt is high (DUT cnt == 1); sample i sees cnt == i+1,
    // and inputs applied at sample i are taken on the edge where cnt == i+1.
    task automatic run_frame(input int nsamp);
        logic [3:0] s, prev;
        for (int c = 0; c < 4; c++) hi[c] = 0;
        rises  = 0;
        fs_cnt = 0;
        prev   = 4'b0000;
        for (int i = 0; i < nsamp; i++) begin
            s = {rght, lft, bck, frnt};
            for (int c = 0; c < 4; c++) begin
                if (s[c]) hi[c]++;
                if (i > 0 && s[c] && !prev[c]) rises++;
            end
            if (frame_strt) fs_cnt++;
            prev = s;
            foreach (chg_q[k]) if (chg_q[k].idx == i) apply(chg_q[k].ch, chg_q[k].val);
            @(negedge clk);
        end
        chg_q.delete();
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({frnt, bck, lft, rght, frame_strt} !== 5'b0) begin
            n_bad++;
            $display("FAIL reset_outputs: got %b expected 00000", {frnt, bck, lft, rght, frame_strt});
        end
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({frnt, bck, lft, rght, frame_strt} !== 5'b11111) begin
            n_bad++;
            $display("FAIL first_load: got %b expected 11111", {frnt, bck, lft, rght, frame_strt});
        end
    endtask

    task automatic test_disarmed;
        // Armed pattern is staged at the start of this frame so the next frame picks it up.
        chg_q.push_back('{0, 4, 11'h001});
        chg_q.push_back('{0, 0, 11'h000});
        chg_q.push_back('{0, 1, 11'h7FF});
        chg_q.push_back('{0, 2, 11'h100});
        chg_q.push_back('{0, 3, 11'h555});
        run_frame(FRAME);
        for (int c = 0; c < 4; c++) begin
            n_cmp++;
            if (hi[c] !== 6250) begin
                n_bad++;
                $display("FAIL disarmed_width %s: got %0d expected 6250", nm[c], hi[c]);
            end
        end
        n_cmp++;
        if (fs_cnt !== 1) begin
            n_bad++;
            $display("FAIL frame_strt_count: got %0d expected 1", fs_cnt);
        end
        n_cmp++;
        if ({frnt, bck, lft, rght, frame_strt} !== 5'b11111) begin
            n_bad++;
            $display("FAIL frame_period: got %b expected 11111", {frnt, bck, lft, rght, frame_strt});
        end
    endtask

    task automatic test_armed;
        int exp_w[4] = '{6250, 12391, 7018, 10345};
        chg_q.push_back('{99, 0, 11'h7FF});
        chg_q.push_back('{FRAME - 3, 2, 11'h000});
        chg_q.push_back('{FRAME - 2, 3, 11'h7FF});
        run_frame(FRAME);
        for (int c = 0; c < 4; c++) begin
            n_cmp++;
            if (hi[c] !== exp_w[c]) begin
                n_bad++;
                $display("FAIL armed_width %s: got %0d expected %0d", nm[c], hi[c], exp_w[c]);
            end
        end
        n_cmp++;
        if (rises !== 0) begin
            n_bad++;
            $display("FAIL midframe_glitch: got %0d extra rises expected 0", rises);
        end
    endtask

    task automatic test_update_timing;
        int exp_w[4] = '{12391, 12391, 6250, 10345};
        chg_q.push_back('{5000, 4, 11'h000});
        run_frame(FRAME);
        for (int c = 0; c < 4; c++) begin
            n_cmp++;
            if (hi[c] !== exp_w[c]) begin
                n_bad++;
                $display("FAIL update_width %s: got %0d expected %0d", nm[c], hi[c], exp_w[c]);
            end
        end
        n_cmp++;
        if (fs_cnt !== 1) begin
            n_bad++;
            $display("FAIL update_frame_strt: got %0d expected 1", fs_cnt);
        end
    endtask

    task automatic test_disarm;
        chg_q.push_back('{16000, 4, 11'h001});
        run_frame(FRAME);
        for (int c = 0; c < 4; c++) begin
            n_cmp++;
            if (hi[c] !== 6250) begin
                n_bad++;
                $display("FAIL disarm_width %s: got %0d expected 6250", nm[c], hi[c]);
            end
        end
    endtask

    task automatic test_reset_mid;
        repeat (3000) @(negedge clk);
        n_cmp++;
        if ({frnt, bck, lft, rght} !== 4'b1111) begin
            n_bad++;
            $display("FAIL pre_reset_high: got %b expected 1111", {frnt, bck, lft, rght});
        end
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({frnt, bck, lft, rght, frame_strt} !== 5'b0) begin
            n_bad++;
            $display("FAIL async_reset: got %b expected 00000", {frnt, bck, lft, rght, frame_strt});
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({frnt, bck, lft, rght, frame_strt} !== 5'b11111) begin
            n_bad++;
            $display("FAIL post_reset_load: got %b expected 11111", {frnt, bck, lft, rght, frame_strt});
        end
        run_frame(7000);
        for (int c = 0; c < 4; c++) begin
            n_cmp++;
            if (hi[c] !== 6250) begin
                n_bad++;
                $display("FAIL post_reset_width %s: got %0d expected 6250", nm[c], hi[c]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_disarmed();
        test_armed();
        test_update_timing();
        test_disarm();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
